// File: rtl/mcpu_alu_pkg.sv
// Shared opcodes, FSM encoding and decode helpers
// for the execute-stage ALU and its iterative mul/div unit.
package mcpu_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/mcpu_muldiv_iter.sv
// Iterative 32-step multiply (shift-add) / divide (restoring)
// unit with start/busy/done handshake and HI/LO result registers.
module mcpu_muldiv_iter
  import mcpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_q, sa_q, sb_q;

  logic               launch, last;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_sh, div_df;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // A new op may enter from IDLE or straight out of DONE
  assign launch = start_i && is_muldiv(op_i) &&
                  (state_q == S_IDLE || state_q == S_DONE);
  assign last   = cnt_q == CW'(WIDTH - 1);

  assign sa    = op_i[0] & a_i[WIDTH-1];
  assign sb    = op_i[0] & b_i[WIDTH-1];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // acc = {partial, multiplier} for mul, {remainder, quotient} for div
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_df  = div_sh - {1'b0, dvs_q};
  assign div_nxt = div_df[WIDTH]
                 ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                 : {div_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Divide-by-zero keeps the all-ones quotient unsigned
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign q_fix = ((sa_q ^ sb_q) && dvs_q != '0)
               ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix = sa_q ? -acc_q[2*WIDTH-1:WIDTH]
                      : acc_q[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: if (launch) state_d = S_BUSY;
      S_BUSY: begin
        busy_o = 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        busy_o  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = launch ? S_BUSY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, iteration steps and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (launch) begin
      acc_q <= {{WIDTH{1'b0}}, mag_a};
      dvs_q <= mag_b;
      div_q <= op_i[1];
      sa_q  <= sa;
      sb_q  <= sb;
      cnt_q <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q <= div_q ? div_nxt : mul_nxt;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == S_FIX) begin
      if (div_q) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end else begin
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix[WIDTH-1:0];
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mcpu_alu_muldiv.sv
// Execute-stage ALU: combinational result mux and flags,
// plus the iterative mul/div unit writing HI/LO.
module mcpu_alu_muldiv
  import mcpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  input  logic             start,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] sum, dif;

  assign shamt = A[SW-1:0];
  assign sum   = A + B;
  assign dif   = A - B;

  // Single-cycle result select and signed-overflow flag
  always_comb begin
    ALUResult = '0;
    Overflow  = 1'b0;
    unique case (ALUCtrl)
      OP_AND:  ALUResult = A & B;
      OP_OR:   ALUResult = A | B;
      OP_ADD: begin
        ALUResult = sum;
        Overflow  = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR:  ALUResult = A ^ B;
      OP_NOR:  ALUResult = ~(A | B);
      OP_LUI:  ALUResult = B << 16;
      OP_SUB: begin
        ALUResult = dif;
        Overflow  = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  ALUResult = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: ALUResult = WIDTH'(A < B);
      OP_SLL:  ALUResult = B << shamt;
      OP_SRL:  ALUResult = B >> shamt;
      OP_SRA:  ALUResult = $unsigned($signed(B) >>> shamt);
      OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: ALUResult = '0;
      default: ALUResult = '0;
    endcase
  end

  assign Zero = ALUResult == '0;

  mcpu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_i     (A),
    .b_i     (B),
    .op_i    (ALUCtrl),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (HI),
    .lo_o    (LO)
  );

endmodule
